run_ctrl: RTL

- Synthesizable run/reset controller that sits between the board (or bench) clock/reset and the priRV32 core.
- Generates a stretched, synchronously released core reset and a bounded run window (cycle budget).
- Watches NUM_MON core status lines (e.g. led) with per-channel activity watchdogs.
- Reports done/fault so benches and FPGA builds share one stop criterion instead of a fixed delay.

---
 rtl/run_ctrl_pkg.sv | 18 +
 rtl/mon_wdt.sv | 53 +++++
 rtl/run_ctrl.sv | 125 ++++++++++++
 3 files changed

// File: rtl/run_ctrl_pkg.sv
// Shared types and constants for the run/reset controller.
// cnt_width gives the width needed to count to max_val, and never returns less than 1.
package run_ctrl_pkg;

   typedef enum logic [1:0] {
      HOLD  = 2'd0,
      RUN   = 2'd1,
      DONE  = 2'd2,
      FAULT = 2'd3
   } run_state_t;

   localparam int SYNC_STAGES = 2;

   function automatic int cnt_width(input int max_val);
      return (max_val < 1) ? 1 : $clog2(max_val + 1);
   endfunction

endpackage

// File: rtl/mon_wdt.sv
// One monitor channel: input synchroniser, either-polarity edge detect,
// activity watchdog and a sticky fault bit.
module mon_wdt
   import run_ctrl_pkg::*;
#(
   parameter int WDT_CYCLES = 1024,
   parameter int CW         = cnt_width(WDT_CYCLES)
)(
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_mon,
   input  logic i_run,
   input  logic i_clr,
   output logic o_fault,
   output logic o_fault_set
);

   logic [SYNC_STAGES-1:0] r_sync;
   logic                   r_prev;
   logic [CW-1:0]          r_cnt;
   logic                   r_fault;
   logic                   w_edge;
   logic                   w_expire;

   assign w_edge      = r_sync[SYNC_STAGES-1] ^ r_prev;
   assign w_expire    = (WDT_CYCLES != 0) && (r_cnt == CW'(WDT_CYCLES - 1));
   // An edge landing on the expiry cycle rescues the channel.
   assign o_fault_set = i_run && !i_clr && !r_fault && !w_edge && w_expire;
   assign o_fault     = r_fault;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_sync  <= '0;
         r_prev  <= 1'b0;
         r_cnt   <= '0;
         r_fault <= 1'b0;
      end else begin
         r_sync <= {r_sync[SYNC_STAGES-2:0], i_mon};
         r_prev <= r_sync[SYNC_STAGES-1];

         if (i_clr || !i_run || w_edge)
            r_cnt <= '0;
         else if (!r_fault && !w_expire)
            r_cnt <= r_cnt + CW'(1);

         if (i_clr)
            r_fault <= 1'b0;
         else if (o_fault_set)
            r_fault <= 1'b1;
      end
   end

endmodule

// File: rtl/run_ctrl.sv
// Run/reset controller: stretched synchronous core reset, bounded run window,
// per-channel activity watchdogs and a shared done/fault stop criterion.
//
// state | meaning
// HOLD  | core held in reset, counting out the release delay
// RUN   | core running, cycle budget and watchdogs active
// DONE  | budget exhausted, core back in reset, done sticky
// FAULT | watchdog fault halted the run, core back in reset
module run_ctrl
   import run_ctrl_pkg::*;
#(
   parameter int RST_HOLD_CYCLES = 4,
   parameter int RUN_CYCLES      = 5000,
   parameter int WDT_CYCLES      = 1024,
   parameter int NUM_MON         = 1,
   parameter int CNT_W           = 32,
   parameter int HALT_ON_FAULT   = 1
)(
   input  logic               i_clk,
   input  logic               i_rst_n,
   input  logic               i_sw_rst_req,
   input  logic [NUM_MON-1:0] i_mon_in,
   output logic               o_core_rst_n,
   output logic               o_running,
   output logic               o_done,
   output logic [NUM_MON-1:0] o_wdt_fault,
   output logic               o_fault_any,
   output logic [CNT_W-1:0]   o_cycle_cnt
);

   localparam int HW = cnt_width(RST_HOLD_CYCLES);

   run_state_t         r_state;
   run_state_t         w_state_nxt;
   logic [HW-1:0]      r_hold_cnt;
   logic [CNT_W-1:0]   r_cycle_cnt;
   logic               r_run;
   logic               r_done;
   logic               r_fault_any;
   logic               w_in_run;
   logic               w_sw_rst;
   logic               w_fault_set;
   logic               w_budget;
   logic [NUM_MON-1:0] w_fault_set_ch;

   assign w_in_run    = (r_state == RUN);
   assign w_sw_rst    = i_sw_rst_req && (r_state != HOLD);
   assign w_fault_set = |w_fault_set_ch;
   assign w_budget    = (RUN_CYCLES != 0) && (r_cycle_cnt == CNT_W'(RUN_CYCLES - 1));

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         HOLD: begin
            if (r_hold_cnt == HW'(RST_HOLD_CYCLES - 1))
               w_state_nxt = RUN;
         end
         RUN: begin
            if (w_sw_rst)
               w_state_nxt = HOLD;
            else if ((HALT_ON_FAULT != 0) && w_fault_set)
               w_state_nxt = FAULT;
            else if (w_budget)
               w_state_nxt = DONE;
         end
         DONE, FAULT: begin
            if (w_sw_rst)
               w_state_nxt = HOLD;
         end
         default: w_state_nxt = HOLD;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state     <= HOLD;
         r_hold_cnt  <= '0;
         r_cycle_cnt <= '0;
         r_run       <= 1'b0;
         r_done      <= 1'b0;
         r_fault_any <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_hold_cnt <= (r_state == HOLD) ? r_hold_cnt + HW'(1) : '0;
         // Registered so the core reset is a clean flop output.
         r_run      <= (w_state_nxt == RUN);

         if (w_sw_rst)
            r_cycle_cnt <= '0;
         else if (w_in_run && (r_cycle_cnt != '1))
            r_cycle_cnt <= r_cycle_cnt + CNT_W'(1);

         if (w_sw_rst)
            r_done <= 1'b0;
         else if (w_in_run && (w_state_nxt == DONE))
            r_done <= 1'b1;

         if (w_sw_rst)
            r_fault_any <= 1'b0;
         else if (w_fault_set)
            r_fault_any <= 1'b1;
      end
   end

   for (genvar g = 0; g < NUM_MON; g++) begin : g_mon
      mon_wdt #(
         .WDT_CYCLES (WDT_CYCLES)
      ) u_mon_wdt (
         .i_clk       (i_clk),
         .i_rst_n     (i_rst_n),
         .i_mon       (i_mon_in[g]),
         .i_run       (w_in_run),
         .i_clr       (w_sw_rst),
         .o_fault     (o_wdt_fault[g]),
         .o_fault_set (w_fault_set_ch[g])
      );
   end

   assign o_core_rst_n = r_run;
   assign o_running    = r_run;
   assign o_done       = r_done;
   assign o_fault_any  = r_fault_any;
   assign o_cycle_cnt  = r_cycle_cnt;

endmodule
